// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Round-robin arbiter/sequencer that shares one nBitAdder between NREQ
//   requesters. One transaction at a time walks IDLE -> EXEC -> RESP: the
//   winner's operands are registered on accept, the sum/carry are registered
//   in EXEC, and the result is held on a tagged response channel in RESP
//   until the consumer takes it.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   req_valid  in   [NREQ-1:0]          requester i has operands pending
//   req_a      in   [NREQ-1:0][N-1:0]   operand A per requester
//   req_b      in   [NREQ-1:0][N-1:0]   operand B per requester
//   req_ready  out  [NREQ-1:0]          one-hot grant (IDLE only)
//   rsp_valid  out  result present
//   rsp_id     out  [IDW-1:0]           owner of the result
//   rsp_sum    out  [N-1:0]             (a + b) mod 2^N
//   rsp_carry  out  bit N of the unsigned sum
//   rsp_ready  in   consumer accepts the result
// -----------------------------------------------------------------------------

// Plain N-bit unsigned adder; the only arithmetic datapath in this block.
module nBitAdder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         carryOut
);
  assign {carryOut, s} = {1'b0, a} + {1'b0, b};
endmodule

module adder_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][N-1:0]    req_a,
  input  logic [NREQ-1:0][N-1:0]    req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic [N-1:0]              rsp_sum,
  output logic                      rsp_carry,
  input  logic                      rsp_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [IDW-1:0]  r_ptr;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [IDW-1:0]  r_id;
  logic [N-1:0]    r_sum;
  logic            r_carry;

  logic            w_found;
  logic [IDW-1:0]  w_winner;
  int              w_scan_idx;
  logic [NREQ-1:0] w_grant;
  logic            w_accept;
  logic [IDW-1:0]  w_ptr_next;
  logic [N-1:0]    w_s;
  logic            w_carry_out;

  // Winner search: first set req_valid bit starting at r_ptr, wrapping
  // modulo NREQ. Depends only on req_valid and r_ptr, never on operands.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = IDW'(w_scan_idx);
      end
    end
  end

  // Grant only in IDLE and never while reset is high, so a requester is
  // never left believing its handshake completed during a reset cycle.
  always_comb begin
    w_grant = '0;
    if (r_state == S_IDLE && !reset && w_found) begin
      w_grant[w_winner] = 1'b1;
    end
  end

  assign w_accept   = |(w_grant & req_valid);
  assign w_ptr_next = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;

  // Adder sees only registered operands; its result only reaches r_sum and
  // r_carry, so no adder path touches an output combinationally.
  nBitAdder #(.N(N)) u_adder (
    .a        (r_a),
    .b        (r_b),
    .s        (w_s),
    .carryOut (w_carry_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. RESP always returns to IDLE, so a new grant cannot
  // share a cycle with the response handshake.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and round-robin pointer. Reset discards any in-flight
  // transaction and returns the pointer to requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= req_a[w_winner];
        r_b   <= req_b[w_winner];
        r_id  <= w_winner;
        r_ptr <= w_ptr_next;
      end
      if (r_state == S_EXEC) begin
        r_sum   <= w_s;
        r_carry <= w_carry_out;
      end
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_carry = r_carry;

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//   Self-checking bench for adder_arbiter. A transaction-level reference model
//   (busy phase counter, round-robin pointer as an integer, expected sum from
//   plain a+b arithmetic) is stepped once per cycle alongside the DUT; every
//   DUT output is compared against it at mid-cycle. Directed scenarios are
//   followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);

  logic                   clk;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0][N-1:0] req_a;
  logic [NREQ-1:0][N-1:0] req_b;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [N-1:0]           rsp_sum;
  logic                   rsp_carry;
  logic                   rsp_ready;

  adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 = free, 1 = adding, 2 = result on offer.
  int          m_phase    = 0;
  int          m_ptr      = 0;
  int          m_id       = 0;
  logic [N:0]  m_exp      = '0;
  bit          m_chk_zero = 1'b0;
  int          m_wait [NREQ];
  int          n_acc      = 0;
  int          n_rsp      = 0;
  int          cyc        = 0;
  int          acc_cyc    = 0;
  int          last_lat   = 0;
  bit          prev_valid = 1'b0;
  logic [N-1:0] last_sum;
  logic         last_carry;
  logic [IDW-1:0] last_id;
  int          g_log[$];
  logic [N-1:0] s_log[$];
  int          i_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  // across the coming rising edge using the inputs currently applied.
  task automatic check_cycle();
    logic [NREQ-1:0] exp_ready;
    int win;
    int g;
    exp_ready = '0;
    win = -1;
    if (!reset && m_phase == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
    if (m_phase == 2) begin
      check("rsp_id",    64'(rsp_id),    64'(m_id));
      check("rsp_sum",   64'(rsp_sum),   64'(m_exp[N-1:0]));
      check("rsp_carry", 64'(rsp_carry), 64'(m_exp[N]));
    end
    if (m_chk_zero) begin
      check("post_rst_valid", 64'(rsp_valid), 64'd0);
      check("post_rst_id",    64'(rsp_id),    64'd0);
      check("post_rst_sum",   64'(rsp_sum),   64'd0);
      check("post_rst_carry", 64'(rsp_carry), 64'd0);
      m_chk_zero = 1'b0;
    end
    if (rsp_valid && !prev_valid) last_lat = cyc - acc_cyc;
    prev_valid = rsp_valid;
    g = -1;
    for (int j = 0; j < NREQ; j++) if (req_ready[j] && req_valid[j]) g = j;
    if (g >= 0) g_log.push_back(g);
    for (int j = 0; j < NREQ; j++) if (!req_valid[j]) m_wait[j] = 0;

    if (reset) begin
      if (m_phase != 0) n_acc--;
      m_phase    = 0;
      m_ptr      = 0;
      m_chk_zero = 1'b1;
    end else begin
      case (m_phase)
        0: if (win >= 0) begin
          check("fair_wait", 64'(m_wait[win] < NREQ), 64'd1);
          for (int j = 0; j < NREQ; j++) if (j != win && req_valid[j]) m_wait[j]++;
          m_wait[win] = 0;
          m_id    = win;
          m_exp   = {1'b0, req_a[win]} + {1'b0, req_b[win]};
          m_ptr   = (win + 1) % NREQ;
          m_phase = 1;
          n_acc++;
          acc_cyc = cyc;
        end
        1: m_phase = 2;
        default: if (rsp_ready) begin
          last_sum   = rsp_sum;
          last_carry = rsp_carry;
          last_id    = rsp_id;
          s_log.push_back(rsp_sum);
          i_log.push_back(int'(rsp_id));
          n_rsp++;
          m_phase = 0;
        end
      endcase
    end
    cyc++;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    #1;
    check_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // One isolated transaction from requester id, then the block drains.
  task automatic run_one(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    req_a[id]     = a;
    req_b[id]     = b;
    rsp_ready     = 1'b1;
    step();
    req_valid = '0;
    repeat (3) step();
  endtask

  function automatic logic [N-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(N-1){1'b0}}};
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    for (int j = 0; j < NREQ; j++) m_wait[j] = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    // First edge only brings the DUT out of X; checking starts afterwards.
    @(posedge clk);
    @(negedge clk);
    m_chk_zero = 1'b1;
    step();
    reset = 1'b0;

    // Single add with latency check.
    run_one(0, 32'd3, 32'd4);
    check("single_sum",   64'(last_sum),   64'd7);
    check("single_carry", 64'(last_carry), 64'd0);
    check("single_id",    64'(last_id),    64'd0);
    check("single_lat",   64'(last_lat),   64'd2);

    // Carry and wrap.
    run_one(2, 32'hFFFF_FFFF, 32'h1);
    check("wrap_sum",   64'(last_sum),   64'd0);
    check("wrap_carry", 64'(last_carry), 64'd1);
    check("wrap_id",    64'(last_id),    64'd2);
    run_one(2, 32'h8000_0000, 32'h8000_0000);
    check("msb_sum",   64'(last_sum),   64'd0);
    check("msb_carry", 64'(last_carry), 64'd1);

    // Round-robin with all requesters held valid from reset.
    do_reset();
    g_log.delete();
    s_log.delete();
    i_log.delete();
    for (int j = 0; j < NREQ; j++) begin
      req_a[j] = N'(j);
      req_b[j] = N'(10 * j);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (15) step();
    check("rr_grants", 64'(g_log.size()), 64'd5);
    check("rr_rsps",   64'(s_log.size()), 64'd5);
    if (g_log.size() >= 5 && s_log.size() >= 5) begin
      int exp_order[5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        check("rr_order", 64'(g_log[k]), 64'(exp_order[k]));
        check("rr_sum",   64'(s_log[k]), 64'(11 * exp_order[k]));
        check("rr_id",    64'(i_log[k]), 64'(exp_order[k]));
      end
    end

    // Backpressure: 5 cycles of rsp_ready low while others are waiting.
    do_reset();
    req_valid    = 4'b0001;
    req_a[0]     = 32'h1234_5678;
    req_b[0]     = 32'hF000_0000;
    rsp_ready    = 1'b0;
    step();
    req_valid = '1;
    step();
    repeat (5) begin
      step();
      check("bp_ready_low", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_done_sum", 64'(last_sum), 64'h0234_5678);
    #1;
    check("bp_next_grant", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    repeat (3) step();

    // Reset during EXEC, then during RESP.
    for (int r = 0; r < 2; r++) begin
      int rsp_before;
      do_reset();
      req_valid = 4'b0100;
      req_a[2]  = 32'd100;
      req_b[2]  = 32'd200;
      rsp_ready = 1'b0;
      step();
      req_valid = '0;
      if (r == 1) step();
      rsp_before = n_rsp;
      reset = 1'b1;
      step();
      reset     = 1'b0;
      req_valid = 4'b1010;
      #1;
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_grant",     64'(req_ready), 64'b0010);
      step();
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (3) step();
      check("rst_no_orphan", 64'(n_rsp - rsp_before), 64'd1);
    end

    // Randomised scoreboard run.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!(req_valid[j] && $urandom_range(0, 3) != 0)) begin
          req_valid[j] = 1'($urandom_range(0, 1));
          req_a[j]     = rnd_op();
          req_b[j]     = rnd_op();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) step();
    check("acc_vs_rsp", 64'(n_rsp), 64'(n_acc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
